// File: rtl/fbuf_pkg.sv
// Shared definitions for the framebuffer scan-out path.
// Contents:
//   - default 640x480@60 raster timing and the derived line/frame totals
//   - RGB332 field positions and the rgb332_expand helper (RGB332 -> RGB888)
//   - raster_flags_t: sync/enable flags carried down the output pipeline
package fbuf_pkg;

    localparam int VGA_WIDTH   = 640;
    localparam int VGA_HEIGHT  = 480;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_H_TOTAL = VGA_WIDTH + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_HEIGHT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int DEF_FBUF_ADDR_WIDTH = 19;
    localparam int DEF_FBUF_DATA_WIDTH = 8;

    localparam int RED_MSB   = 7;
    localparam int RED_LSB   = 5;
    localparam int GREEN_MSB = 4;
    localparam int GREEN_LSB = 2;
    localparam int BLUE_MSB  = 1;
    localparam int BLUE_LSB  = 0;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic first;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, first: 1'b0};

    // Bit replication keeps full-scale codes at full scale (7 -> FF, 3 -> FF).
    function automatic rgb888_t rgb332_expand(input logic [7:0] pix);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        rgb888_t    res;
        r         = pix[RED_MSB:RED_LSB];
        g         = pix[GREEN_MSB:GREEN_LSB];
        b         = pix[BLUE_MSB:BLUE_LSB];
        res.red   = {r, r, r[2:1]};
        res.green = {g, g, g[2:1]};
        res.blue  = {b, b, b, b};
        return res;
    endfunction

endpackage

// File: rtl/fbuf_scanout_if.sv
// Framebuffer synchronous read port.
//   rd_address : read address (master -> RAM)
//   rd_en      : read enable  (master -> RAM)
//   rd_data    : read data, valid one clock after rd_en (RAM -> master)
// Modports: master = scan-out reader, slave = framebuffer RAM.
interface fbuf_rd_if
    import fbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_FBUF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_FBUF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output rd_address, output rd_en, input rd_data);
    modport slave  (input rd_address, input rd_en, output rd_data);
endinterface

// File: rtl/fbuf_scanout_timing.sv
// video_timing_gen: raster position counters and the flags derived from them.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   h, v        : current raster column / line
//   active      : inside the visible W x H area
//   hsync/vsync : sync pulses, active low, undelayed
//   line_end    : last clock of every line
//   frame_end   : last clock of the last line
module video_timing_gen
    import fbuf_pkg::*;
#(
    parameter int W      = VGA_WIDTH,
    parameter int H      = VGA_HEIGHT,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    localparam int H_TOTAL = W + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = H + V_FP + V_SYNC + V_BP,
    localparam int HCW     = $clog2(H_TOTAL),
    localparam int VCW     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [HCW-1:0] h,
    output logic [VCW-1:0] v,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           line_end,
    output logic           frame_end
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= (v == VCW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign line_end  = (h == HCW'(H_TOTAL - 1));
    assign frame_end = line_end && (v == VCW'(V_TOTAL - 1));
    assign active    = (h < HCW'(W)) && (v < VCW'(H));
    assign hsync     = !((h >= HCW'(W + H_FP)) && (h <= HCW'(W + H_FP + H_SYNC - 1)));
    assign vsync     = !((v >= VCW'(H + V_FP)) && (v <= VCW'(H + V_FP + V_SYNC - 1)));

endmodule

// File: rtl/fbuf_scanout.sv
// fbuf_scanout: sweeps the raster, reads one RGB332 pixel per active clock
// from the framebuffer and drives sync, DE and RGB888 to the video encoder.
// Pipeline: C0 counters -> C1 read address/enable -> C2 RAM data -> C3 outputs;
// sync/DE/frame_start ride a matching delay so all vid_* outputs align.
// Ports:
//   clk, rst_n           : pixel clock, asynchronous active-low reset
//   pixel_fbuf           : fbuf_rd_if.master read port (rd_address, rd_en, rd_data)
//   vid_hsync/vid_vsync  : active-low syncs
//   vid_de               : active video
//   vid_red/green/blue   : expanded colour, zero outside active video
//   frame_start          : one-clock pulse with output pixel (0,0)
// Optional build macro FBUF_SCANOUT_BORDER_EN: paints a one-pixel white
// frame around the picture (RAM is still read for those pixels).
module fbuf_scanout
    import fbuf_pkg::*;
#(
    parameter int FRAME_WIDTH     = VGA_WIDTH,
    parameter int FRAME_HEIGHT    = VGA_HEIGHT,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int SCALING_FACTOR  = 1,
    parameter int FBUF_ADDR_WIDTH = DEF_FBUF_ADDR_WIDTH,
    parameter int FBUF_DATA_WIDTH = DEF_FBUF_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    fbuf_rd_if.master  pixel_fbuf,
    output logic       vid_hsync,
    output logic       vid_vsync,
    output logic       vid_de,
    output logic [7:0] vid_red,
    output logic [7:0] vid_green,
    output logic [7:0] vid_blue,
    output logic       frame_start
);

    localparam int HCW = $clog2(FRAME_WIDTH + H_FP + H_SYNC + H_BP);
    localparam int VCW = $clog2(FRAME_HEIGHT + V_FP + V_SYNC + V_BP);
    localparam int XSW = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
    localparam logic [FBUF_ADDR_WIDTH-1:0] LINE_STEP =
        FBUF_ADDR_WIDTH'(FRAME_WIDTH / SCALING_FACTOR);

    generate
        if (FBUF_DATA_WIDTH != 8) begin : g_bad_data_width
            $error("fbuf_scanout: FBUF_DATA_WIDTH must be 8 (RGB332)");
        end
        if ((FRAME_WIDTH % SCALING_FACTOR) != 0 || (FRAME_HEIGHT % SCALING_FACTOR) != 0) begin : g_bad_scale
            $error("fbuf_scanout: SCALING_FACTOR must divide the frame size");
        end
    endgenerate

    logic [HCW-1:0]             h;
    logic [VCW-1:0]             v;
    logic                       active;
    logic                       hsync_c;
    logic                       vsync_c;
    logic                       line_end;
    logic                       frame_end;
    logic [XSW-1:0]             xs;
    logic [XSW-1:0]             xs_cur;
    logic [XSW-1:0]             ys;
    logic [FBUF_ADDR_WIDTH-1:0] addr;
    logic [FBUF_ADDR_WIDTH-1:0] pix_addr;
    logic [FBUF_ADDR_WIDTH-1:0] line_base;
    raster_flags_t              flags_c0;
    raster_flags_t              flags_c1;
    raster_flags_t              flags_c2;
    rgb888_t                    pix_rgb;

    video_timing_gen #(
        .W(FRAME_WIDTH), .H(FRAME_HEIGHT),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .h(h), .v(v), .active(active),
        .hsync(hsync_c), .vsync(vsync_c), .line_end(line_end), .frame_end(frame_end)
    );

    // The first pixel of a line takes its address straight from line_base, so
    // addr only ever needs to track the next pixel within the current line.
    always_comb begin
        pix_addr = addr;
        xs_cur   = xs;
        if (h == '0) begin
            pix_addr = line_base;
            xs_cur   = '0;
        end
    end

    // Replication by counting: xs spaces out address increments along a line,
    // ys decides how many lines reuse the same line_base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs        <= '0;
            ys        <= '0;
            addr      <= '0;
            line_base <= '0;
        end else begin
            if (active) begin
                if (xs_cur == XSW'(SCALING_FACTOR - 1)) begin
                    xs   <= '0;
                    addr <= pix_addr + 1'b1;
                end else begin
                    xs   <= xs_cur + 1'b1;
                    addr <= pix_addr;
                end
            end
            if (frame_end) begin
                ys        <= '0;
                line_base <= '0;
            end else if (line_end && (v < VCW'(FRAME_HEIGHT))) begin
                if (ys == XSW'(SCALING_FACTOR - 1)) begin
                    ys        <= '0;
                    line_base <= line_base + LINE_STEP;
                end else begin
                    ys <= ys + 1'b1;
                end
            end
        end
    end

    // Address is held through blanking so the RAM port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_fbuf.rd_address <= '0;
            pixel_fbuf.rd_en      <= 1'b0;
        end else begin
            pixel_fbuf.rd_en <= active;
            if (active) begin
                pixel_fbuf.rd_address <= pix_addr;
            end
        end
    end

    always_comb begin
        flags_c0       = FLAGS_IDLE;
        flags_c0.hsync = hsync_c;
        flags_c0.vsync = vsync_c;
        flags_c0.de    = active;
        flags_c0.first = active && (h == '0) && (v == '0);
    end

    assign pix_rgb = rgb332_expand(pixel_fbuf.rd_data);

`ifdef FBUF_SCANOUT_BORDER_EN
    logic border_c0;
    logic border_c1;
    logic border_c2;

    assign border_c0 = active && ((h == '0) || (h == HCW'(FRAME_WIDTH - 1)) ||
                                  (v == '0) || (v == VCW'(FRAME_HEIGHT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            border_c1 <= 1'b0;
            border_c2 <= 1'b0;
        end else begin
            border_c1 <= border_c0;
            border_c2 <= border_c1;
        end
    end
`endif

    // flags_c2 lines up with the RAM data, so the final register stage applies
    // to both and everything leaves in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_c1    <= FLAGS_IDLE;
            flags_c2    <= FLAGS_IDLE;
            vid_hsync   <= 1'b1;
            vid_vsync   <= 1'b1;
            vid_de      <= 1'b0;
            frame_start <= 1'b0;
            vid_red     <= '0;
            vid_green   <= '0;
            vid_blue    <= '0;
        end else begin
            flags_c1    <= flags_c0;
            flags_c2    <= flags_c1;
            vid_hsync   <= flags_c2.hsync;
            vid_vsync   <= flags_c2.vsync;
            vid_de      <= flags_c2.de;
            frame_start <= flags_c2.first;
            if (!flags_c2.de) begin
                vid_red   <= '0;
                vid_green <= '0;
                vid_blue  <= '0;
`ifdef FBUF_SCANOUT_BORDER_EN
            end else if (border_c2) begin
                vid_red   <= 8'hFF;
                vid_green <= 8'hFF;
                vid_blue  <= 8'hFF;
`endif
            end else begin
                vid_red   <= pix_rgb.red;
                vid_green <= pix_rgb.green;
                vid_blue  <= pix_rgb.blue;
            end
        end
    end

endmodule

// File: tb/tb_fbuf_scanout.sv
// Testbench for fbuf_scanout.
// dut_a: default 640x480 raster, scale 1, RAM returns E0 at 0, 03 at 1, else addr[7:0].
// dut_b: tiny 8x4 raster (16x8 total), scale 2, RAM returns addr[7:0].
module tb_fbuf_scanout;
    import fbuf_pkg::*;

    typedef struct {
        int          k;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
        logic        rden;
        int          addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    vec_t vecs[$];

    logic       hs_a, vs_a, de_a, fs_a;
    logic [7:0] red_a, green_a, blue_a;
    logic       hs_b, vs_b, de_b, fs_b;
    logic [7:0] red_b, green_b, blue_b;

    always #5 clk = ~clk;

    fbuf_rd_if #(.ADDR_WIDTH(19), .DATA_WIDTH(8)) fb_a ();
    fbuf_rd_if #(.ADDR_WIDTH(19), .DATA_WIDTH(8)) fb_b ();

    fbuf_scanout dut_a (
        .clk(clk), .rst_n(rst_n_a), .pixel_fbuf(fb_a),
        .vid_hsync(hs_a), .vid_vsync(vs_a), .vid_de(de_a),
        .vid_red(red_a), .vid_green(green_a), .vid_blue(blue_a),
        .frame_start(fs_a)
    );

    fbuf_scanout #(
        .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
        .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALING_FACTOR(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .pixel_fbuf(fb_b),
        .vid_hsync(hs_b), .vid_vsync(vs_b), .vid_de(de_b),
        .vid_red(red_b), .vid_green(green_b), .vid_blue(blue_b),
        .frame_start(fs_b)
    );

    function automatic logic [7:0] ram_a(input logic [18:0] a);
        if (a == 19'd0) return 8'hE0;
        if (a == 19'd1) return 8'h03;
        return a[7:0];
    endfunction

    always @(posedge clk) if (fb_a.rd_en) fb_a.rd_data <= ram_a(fb_a.rd_address);
    always @(posedge clk) if (fb_b.rd_en) fb_b.rd_data <= fb_b.rd_address[7:0];

    // Clocks since reset release; outputs seen during count k describe raster position k-3.
    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) cyc_a <= 0;
        else          cyc_a <= cyc_a + 1;
    end
    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) cyc_b <= 0;
        else          cyc_b <= cyc_b + 1;
    end

    function automatic logic [23:0] expand332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic add_vec(input int k, input logic de, input logic hs, input logic vs, input logic fs,
                           input logic [23:0] rgb, input logic rden, input int addr);
        vec_t t;
        t.k = k; t.de = de; t.hs = hs; t.vs = vs; t.fs = fs;
        t.rgb = rgb; t.rden = rden; t.addr = addr;
        vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input int k);
        int guard;
        guard = 0;
        while (cyc_a < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc_a != k) begin
            total++;
            bad++;
            $display("[TB] FAIL sync_a: got=%0d want=%0d", cyc_a, k);
        end
    endtask

    function automatic logic [23:0] border_a(input int k, input logic de, input logic [23:0] rgb);
        int p, x, y;
        p = k - 3;
        x = p % 800;
        y = p / 800;
`ifdef FBUF_SCANOUT_BORDER_EN
        if (de && (x == 0 || x == 639 || y == 0 || y == 479)) return 24'hFFFFFF;
`endif
        return rgb;
    endfunction

    task automatic check_reset_a(input string tag);
        check_output({tag, "_addr"}, fb_a.rd_address, 0);
        check_output({tag, "_rden"}, fb_a.rd_en, 0);
        check_output({tag, "_hs"}, hs_a, 1);
        check_output({tag, "_vs"}, vs_a, 1);
        check_output({tag, "_de"}, de_a, 0);
        check_output({tag, "_fs"}, fs_a, 0);
        check_output({tag, "_rgb"}, {red_a, green_a, blue_a}, 0);
    endtask

    // dut_a: colour must be black outside DE, and DE must trail rd_en by two clocks.
    logic rden_a_d1 = 1'b0;
    logic rden_a_d2 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n_a) begin
            rden_a_d1 <= 1'b0;
            rden_a_d2 <= 1'b0;
        end else begin
            if (!de_a) check_output("blank_rgb_a", {red_a, green_a, blue_a}, 0);
            check_output("de_vs_rden_a", de_a, rden_a_d2);
            rden_a_d2 <= rden_a_d1;
            rden_a_d1 <= fb_a.rd_en;
        end
    end

    // dut_b reference: position-based model of the 16x8 raster with 2x replication.
    task automatic check_b_cycle(input int k);
        int p, h, v, a;
        logic exp_de, exp_hs, exp_vs, exp_fs;
        logic [23:0] exp_rgb;
        logic [7:0] byte_v;
        p = k - 1;
        if (p < 0) begin
            check_output("rden_b_idle", fb_b.rd_en, 0);
        end else begin
            h = p % 16;
            v = (p / 16) % 8;
            check_output("rden_b", fb_b.rd_en, (h < 8 && v < 4));
            if (h < 8 && v < 4) check_output("addr_b", fb_b.rd_address, (v / 2) * 4 + h / 2);
        end
        p = k - 3;
        exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0; exp_rgb = '0;
        if (p >= 0) begin
            h = p % 16;
            v = (p / 16) % 8;
            exp_de = (h < 8 && v < 4);
            exp_hs = !(h >= 10 && h <= 12);
            exp_vs = !(v >= 5 && v <= 6);
            exp_fs = exp_de && h == 0 && v == 0;
            a = (v / 2) * 4 + h / 2;
            byte_v = a[7:0];
            if (exp_de) exp_rgb = expand332(byte_v);
`ifdef FBUF_SCANOUT_BORDER_EN
            if (exp_de && (h == 0 || h == 7 || v == 0 || v == 3)) exp_rgb = 24'hFFFFFF;
`endif
        end
        check_output("de_b", de_b, exp_de);
        check_output("hs_b", hs_b, exp_hs);
        check_output("vs_b", vs_b, exp_vs);
        check_output("fs_b", fs_b, exp_fs);
        check_output("rgb_b", {red_b, green_b, blue_b}, exp_rgb);
    endtask

    int cnt_rden_b = 0, cnt_hs_b = 0, cnt_vs_b = 0, cnt_fs_b = 0, max_addr_b = 0;
    always @(negedge clk) begin
        if (rst_n_b) begin
            check_b_cycle(cyc_b);
            if (cyc_b >= 1 && cyc_b < 257 && fb_b.rd_en) begin
                cnt_rden_b <= cnt_rden_b + 1;
                if (int'(fb_b.rd_address) > max_addr_b) max_addr_b <= int'(fb_b.rd_address);
            end
            if (cyc_b >= 3 && cyc_b < 259) begin
                if (!hs_b) cnt_hs_b <= cnt_hs_b + 1;
                if (!vs_b) cnt_vs_b <= cnt_vs_b + 1;
                if (fs_b)  cnt_fs_b <= cnt_fs_b + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t t;
        // k, de, hs, vs, fs, rgb, rd_en, rd_address
        add_vec(0,   0, 1, 1, 0, 24'h000000, 0, 0);
        add_vec(1,   0, 1, 1, 0, 24'h000000, 1, 0);
        add_vec(2,   0, 1, 1, 0, 24'h000000, 1, 1);
        add_vec(3,   1, 1, 1, 1, 24'hFF0000, 1, 2);
        add_vec(4,   1, 1, 1, 0, 24'h0000FF, 1, 3);
        add_vec(5,   1, 1, 1, 0, 24'h0000AA, 1, 4);
        add_vec(103, 1, 1, 1, 0, 24'h6D2400, 1, 102);
        add_vec(642, 1, 1, 1, 0, 24'h6DFFFF, 0, 639);
        add_vec(643, 0, 1, 1, 0, 24'h000000, 0, 639);
        add_vec(658, 0, 1, 1, 0, 24'h000000, 0, 639);
        add_vec(659, 0, 0, 1, 0, 24'h000000, 0, 639);
        add_vec(754, 0, 0, 1, 0, 24'h000000, 0, 639);
        add_vec(755, 0, 1, 1, 0, 24'h000000, 0, 639);
        add_vec(801, 0, 1, 1, 0, 24'h000000, 1, 640);
        add_vec(803, 1, 1, 1, 0, 24'h920000, 1, 642);
        add_vec(808, 1, 1, 1, 0, 24'h922455, 1, 647);

        repeat (3) @(negedge clk);
        check_reset_a("por");
        #2;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        foreach (vecs[i]) begin
            t = vecs[i];
            apply_stimulus(t.k);
            check_output($sformatf("de@%0d", t.k), de_a, t.de);
            check_output($sformatf("hs@%0d", t.k), hs_a, t.hs);
            check_output($sformatf("vs@%0d", t.k), vs_a, t.vs);
            check_output($sformatf("fs@%0d", t.k), fs_a, t.fs);
            check_output($sformatf("rgb@%0d", t.k), {red_a, green_a, blue_a}, border_a(t.k, t.de, t.rgb));
            check_output($sformatf("rden@%0d", t.k), fb_a.rd_en, t.rden);
            check_output($sformatf("addr@%0d", t.k), fb_a.rd_address, t.addr);
        end

        // Mid-frame reset at h=300, v=1: outputs must drop without waiting for a clock.
        apply_stimulus(1103);
        check_output("pre_rst_de", de_a, 1);
        #2;
        rst_n_a = 1'b0;
        #1;
        check_reset_a("async_rst");
        @(negedge clk);
        #2;
        rst_n_a = 1'b1;
        apply_stimulus(1);
        check_output("rst1_rden", fb_a.rd_en, 1);
        check_output("rst1_addr", fb_a.rd_address, 0);
        apply_stimulus(2);
        check_output("rst2_de", de_a, 0);
        check_output("rst2_fs", fs_a, 0);
        apply_stimulus(3);
        check_output("rst3_de", de_a, 1);
        check_output("rst3_fs", fs_a, 1);
        check_output("rst3_rgb", {red_a, green_a, blue_a}, border_a(3, 1'b1, 24'hFF0000));

        // Two full frames of dut_b have been tallied by now.
        check_output("b_rden_count", cnt_rden_b, 64);
        check_output("b_hsync_low", cnt_hs_b, 48);
        check_output("b_vsync_low", cnt_vs_b, 64);
        check_output("b_frame_starts", cnt_fs_b, 2);
        check_output("b_last_addr", max_addr_b, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
